wshb_arbiter_2m: RTL

//  Two-master -> one-slave Wishbone B3 (classic) arbiter that shares the SDRAM port.

---
 rtl/wshb_arb_pkg.sv | 15 +
 rtl/wshb_arbiter_2m.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/wshb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wshb_arb_pkg;

  // Arbiter FSM states. The encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  // Arbitration policy selectors for PRIO_MODE.
  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

endpackage

// File: rtl/wshb_arbiter_2m.sv
// Two-master to one-slave Wishbone B3 classic arbiter in front of the SDRAM port.
// Master 0 is the video read path, master 1 the pattern/pixel writer.
//
// Handshake: a master requests by raising cyc and keeps it high for as long as it
// wants the bus. stb marks a valid beat. A beat completes on a clock edge where
// stb and ack (or err or rty) are both high. Ownership is re-decided only on an
// edge where the current owner's cyc is low. grant is the debug view of the FSM
// state: 2'b00 idle, 2'b01 master 0, 2'b10 master 1.
module wshb_arbiter_2m
  import wshb_arb_pkg::*;
#(
  parameter int PRIO_MODE = PRIO_RR,
  parameter int ADR_W     = 32,
  parameter int DAT_W     = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  // master 0 port
  input  logic               ifs0_cyc,
  input  logic               ifs0_stb,
  input  logic               ifs0_we,
  input  logic [ADR_W-1:0]   ifs0_adr,
  input  logic [DAT_W/8-1:0] ifs0_sel,
  input  logic [DAT_W-1:0]   ifs0_dat_ms,
  input  logic [2:0]         ifs0_cti,
  input  logic [1:0]         ifs0_bte,
  output logic               ifs0_ack,
  output logic               ifs0_err,
  output logic               ifs0_rty,
  output logic [DAT_W-1:0]   ifs0_dat_sm,
  // master 1 port
  input  logic               ifs1_cyc,
  input  logic               ifs1_stb,
  input  logic               ifs1_we,
  input  logic [ADR_W-1:0]   ifs1_adr,
  input  logic [DAT_W/8-1:0] ifs1_sel,
  input  logic [DAT_W-1:0]   ifs1_dat_ms,
  input  logic [2:0]         ifs1_cti,
  input  logic [1:0]         ifs1_bte,
  output logic               ifs1_ack,
  output logic               ifs1_err,
  output logic               ifs1_rty,
  output logic [DAT_W-1:0]   ifs1_dat_sm,
  // slave (SDRAM controller) port
  output logic               ifm_cyc,
  output logic               ifm_stb,
  output logic               ifm_we,
  output logic [ADR_W-1:0]   ifm_adr,
  output logic [DAT_W/8-1:0] ifm_sel,
  output logic [DAT_W-1:0]   ifm_dat_ms,
  output logic [2:0]         ifm_cti,
  output logic [1:0]         ifm_bte,
  input  logic               ifm_ack,
  input  logic               ifm_err,
  input  logic               ifm_rty,
  input  logic [DAT_W-1:0]   ifm_dat_sm,
  // debug
  output logic [1:0]         grant
);

  arb_state_t state, state_nx;
  logic       last_owner;  // 1 after reset so master 0 wins the first round-robin tie

  // State register and last-owner tracking; reset aborts any transfer at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_owner <= 1'b1;
    end else begin
      state <= state_nx;
      if (state == OWN0 && !ifs0_cyc) last_owner <= 1'b0;
      if (state == OWN1 && !ifs1_cyc) last_owner <= 1'b1;
    end
  end

  // Next-state decision: owner keeps the bus while cyc is high, hand-over needs no idle cycle.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (ifs0_cyc && ifs1_cyc) begin
          if (PRIO_MODE == PRIO_FIXED) state_nx = OWN0;
          else                         state_nx = last_owner ? OWN0 : OWN1;
        end else if (ifs0_cyc) begin
          state_nx = OWN0;
        end else if (ifs1_cyc) begin
          state_nx = OWN1;
        end
      end
      OWN0:    if (!ifs0_cyc) state_nx = ifs1_cyc ? OWN1 : IDLE;
      OWN1:    if (!ifs1_cyc) state_nx = ifs0_cyc ? OWN0 : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Slave-side mux and owner-only return path, both driven purely from the state.
  always_comb begin
    ifm_cyc    = 1'b0;
    ifm_stb    = 1'b0;
    ifm_we     = 1'b0;
    ifm_adr    = '0;
    ifm_sel    = '0;
    ifm_dat_ms = '0;
    ifm_cti    = '0;
    ifm_bte    = '0;
    ifs0_ack   = 1'b0;
    ifs0_err   = 1'b0;
    ifs0_rty   = 1'b0;
    ifs1_ack   = 1'b0;
    ifs1_err   = 1'b0;
    ifs1_rty   = 1'b0;
    grant      = 2'b00;
    case (state)
      OWN0: begin
        ifm_cyc    = ifs0_cyc;
        ifm_stb    = ifs0_stb;
        ifm_we     = ifs0_we;
        ifm_adr    = ifs0_adr;
        ifm_sel    = ifs0_sel;
        ifm_dat_ms = ifs0_dat_ms;
        ifm_cti    = ifs0_cti;
        ifm_bte    = ifs0_bte;
        ifs0_ack   = ifm_ack;
        ifs0_err   = ifm_err;
        ifs0_rty   = ifm_rty;
        grant      = 2'b01;
      end
      OWN1: begin
        ifm_cyc    = ifs1_cyc;
        ifm_stb    = ifs1_stb;
        ifm_we     = ifs1_we;
        ifm_adr    = ifs1_adr;
        ifm_sel    = ifs1_sel;
        ifm_dat_ms = ifs1_dat_ms;
        ifm_cti    = ifs1_cti;
        ifm_bte    = ifs1_bte;
        ifs1_ack   = ifm_ack;
        ifs1_err   = ifm_err;
        ifs1_rty   = ifm_rty;
        grant      = 2'b10;
      end
      default: ;
    endcase
  end

  // Read data is broadcast; masters only look at it when they see their own ack.
  assign ifs0_dat_sm = ifm_dat_sm;
  assign ifs1_dat_sm = ifm_dat_sm;

  // Protocol sanity checks.
  a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
  a_ack0_owner:    assert property (@(posedge clk) disable iff (!rst_n) ifs0_ack |-> grant == 2'b01);
  a_ack1_owner:    assert property (@(posedge clk) disable iff (!rst_n) ifs1_ack |-> grant == 2'b10);
  a_slave_stb:     assert property (@(posedge clk) disable iff (!rst_n) ifm_stb |-> ifm_cyc);
  a_m0_stb_cyc:    assert property (@(posedge clk) disable iff (!rst_n) ifs0_stb |-> ifs0_cyc);
  a_m1_stb_cyc:    assert property (@(posedge clk) disable iff (!rst_n) ifs1_stb |-> ifs1_cyc);

endmodule
